decode_step: RTL

//  Decode ("coz") stage directly downstream of the fetch stage. Buffers fetched instructions in a small queue and decodes RV32I fields.

---
 rtl/decode_pkg.sv | 33 +++
 rtl/decode_fields.sv | 64 ++++++
 rtl/decode_step.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/decode_pkg.sv
// Shared definitions for the decode stage: RV32I opcodes, op-class enum and queue depth default.
package decode_pkg;

  localparam int DERINLIK_VARSAYILAN = 2;

  localparam logic [6:0] OP_ALU_R  = 7'b0110011;
  localparam logic [6:0] OP_ALU_I  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    SINIF_ALU_R   = 4'd0,
    SINIF_ALU_I   = 4'd1,
    SINIF_LOAD    = 4'd2,
    SINIF_STORE   = 4'd3,
    SINIF_BRANCH  = 4'd4,
    SINIF_JAL     = 4'd5,
    SINIF_JALR    = 4'd6,
    SINIF_LUI     = 4'd7,
    SINIF_AUIPC   = 4'd8,
    SINIF_FENCE   = 4'd9,
    SINIF_SYSTEM  = 4'd10,
    SINIF_ILLEGAL = 4'd11
  } sinif_t;

endpackage

// File: rtl/decode_fields.sv
// Combinational RV32I field decoder: instruction word -> op class, register fields, funct bits, immediate.
module decode_fields
  import decode_pkg::*;
(
  input  logic [31:0] buyruk,
  output logic [3:0]  sinif,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  f3,
  output logic        f7b5,
  output logic [31:0] anlik,
  output logic        yasadisi
);

  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
  sinif_t      sinif_s;

  assign imm_i_s = {{20{buyruk[31]}}, buyruk[31:20]};
  assign imm_s_s = {{20{buyruk[31]}}, buyruk[31:25], buyruk[11:7]};
  assign imm_b_s = {{19{buyruk[31]}}, buyruk[31], buyruk[7], buyruk[30:25], buyruk[11:8], 1'b0};
  assign imm_u_s = {buyruk[31:12], 12'd0};
  assign imm_j_s = {{11{buyruk[31]}}, buyruk[31], buyruk[19:12], buyruk[20], buyruk[30:21], 1'b0};

  // Opcode classification and immediate format selection; compressed encodings are rejected outright.
  always_comb begin
    sinif_s  = SINIF_ILLEGAL;
    anlik    = 32'd0;
    yasadisi = 1'b1;
    if (buyruk[1:0] == 2'b11) begin
      yasadisi = 1'b0;
      case (buyruk[6:0])
        OP_ALU_R:  sinif_s = SINIF_ALU_R;
        OP_ALU_I:  begin sinif_s = SINIF_ALU_I;  anlik = imm_i_s; end
        OP_LOAD:   begin sinif_s = SINIF_LOAD;   anlik = imm_i_s; end
        OP_STORE:  begin sinif_s = SINIF_STORE;  anlik = imm_s_s; end
        OP_BRANCH: begin sinif_s = SINIF_BRANCH; anlik = imm_b_s; end
        OP_JAL:    begin sinif_s = SINIF_JAL;    anlik = imm_j_s; end
        OP_JALR:   begin sinif_s = SINIF_JALR;   anlik = imm_i_s; end
        OP_LUI:    begin sinif_s = SINIF_LUI;    anlik = imm_u_s; end
        OP_AUIPC:  begin sinif_s = SINIF_AUIPC;  anlik = imm_u_s; end
        OP_FENCE:  begin sinif_s = SINIF_FENCE;  anlik = imm_i_s; end
        OP_SYSTEM: begin sinif_s = SINIF_SYSTEM; anlik = imm_i_s; end
        default: begin
          sinif_s  = SINIF_ILLEGAL;
          anlik    = 32'd0;
          yasadisi = 1'b1;
        end
      endcase
    end else begin
      sinif_s  = SINIF_ILLEGAL;
      anlik    = 32'd0;
      yasadisi = 1'b1;
    end
  end

  assign sinif = sinif_s;
  assign rd    = buyruk[11:7];
  assign rs1   = buyruk[19:15];
  assign rs2   = buyruk[24:20];
  assign f3    = yasadisi ? 3'd0 : buyruk[14:12];
  assign f7b5  = yasadisi ? 1'b0 : buyruk[30];

endmodule

// File: rtl/decode_step.sv
// Decode stage: small instruction queue from fetch, one registered decoded instruction per cycle to execute.
module decode_step
  import decode_pkg::*;
#(
  parameter int DERINLIK = DERINLIK_VARSAYILAN,
  parameter int PS_W     = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     getir_buyruk_i,
  input  logic            getir_buyruk_gecerli_i,
  input  logic [PS_W-1:0] getir_ps_i,
  output logic            coz_bos_o,
  input  logic            bosalt_i,
  input  logic            yurut_hazir_i,
  output logic            yurut_gecerli_o,
  output logic [PS_W-1:0] yurut_ps_o,
  output logic [3:0]      yurut_sinif_o,
  output logic [4:0]      yurut_rd_o,
  output logic [4:0]      yurut_rs1_o,
  output logic [4:0]      yurut_rs2_o,
  output logic [2:0]      yurut_f3_o,
  output logic            yurut_f7b5_o,
  output logic [31:0]     yurut_anlik_o,
  output logic            yurut_yasadisi_o
);

  localparam int AW = $clog2(DERINLIK);
  localparam logic [AW:0] DERINLIK_C = (AW+1)'(DERINLIK);

  logic [31:0]     buyruk_mem_r [DERINLIK];
  logic [PS_W-1:0] ps_mem_r     [DERINLIK];
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [AW:0]     count_r;

  logic push_s, pop_s, yukle_s, dolu_degil_s;
  logic [3:0]  d_sinif_s;
  logic [4:0]  d_rd_s, d_rs1_s, d_rs2_s;
  logic [2:0]  d_f3_s;
  logic        d_f7b5_s, d_yasadisi_s;
  logic [31:0] d_anlik_s;

  logic            gecerli_r, f7b5_r, yasadisi_r;
  logic [PS_W-1:0] ps_r;
  logic [3:0]      sinif_r;
  logic [4:0]      rd_r, rs1_r, rs2_r;
  logic [2:0]      f3_r;
  logic [31:0]     anlik_r;

  assign coz_bos_o    = (count_r < DERINLIK_C);
  assign dolu_degil_s = (count_r != '0);
  assign yukle_s      = ~gecerli_r | yurut_hazir_i;
  // Flush suppresses both queue operations so a same-cycle fetch word is lost on purpose.
  assign push_s       = getir_buyruk_gecerli_i & coz_bos_o & ~bosalt_i;
  assign pop_s        = yukle_s & dolu_degil_s & ~bosalt_i;

  decode_fields u_fields (
    .buyruk   (buyruk_mem_r[rd_ptr_r]),
    .sinif    (d_sinif_s),
    .rd       (d_rd_s),
    .rs1      (d_rs1_s),
    .rs2      (d_rs2_s),
    .f3       (d_f3_s),
    .f7b5     (d_f7b5_s),
    .anlik    (d_anlik_s),
    .yasadisi (d_yasadisi_s)
  );

  // Queue storage; contents are don't-care until counted in.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      buyruk_mem_r[wr_ptr_r] <= getir_buyruk_i;
      ps_mem_r[wr_ptr_r]     <= getir_ps_i;
    end
  end

  // Queue pointers and occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (bosalt_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Output register toward execute: loads from the queue head whenever the current output is free or taken.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gecerli_r  <= 1'b0;
      ps_r       <= '0;
      sinif_r    <= 4'd0;
      rd_r       <= 5'd0;
      rs1_r      <= 5'd0;
      rs2_r      <= 5'd0;
      f3_r       <= 3'd0;
      f7b5_r     <= 1'b0;
      anlik_r    <= 32'd0;
      yasadisi_r <= 1'b0;
    end else if (bosalt_i) begin
      gecerli_r <= 1'b0;
    end else if (yukle_s) begin
      if (dolu_degil_s) begin
        gecerli_r  <= 1'b1;
        ps_r       <= ps_mem_r[rd_ptr_r];
        sinif_r    <= d_sinif_s;
        rd_r       <= d_rd_s;
        rs1_r      <= d_rs1_s;
        rs2_r      <= d_rs2_s;
        f3_r       <= d_f3_s;
        f7b5_r     <= d_f7b5_s;
        anlik_r    <= d_anlik_s;
        yasadisi_r <= d_yasadisi_s;
      end else begin
        gecerli_r <= 1'b0;
      end
    end
  end

  assign yurut_gecerli_o  = gecerli_r;
  assign yurut_ps_o       = ps_r;
  assign yurut_sinif_o    = sinif_r;
  assign yurut_rd_o       = rd_r;
  assign yurut_rs1_o      = rs1_r;
  assign yurut_rs2_o      = rs2_r;
  assign yurut_f3_o       = f3_r;
  assign yurut_f7b5_o     = f7b5_r;
  assign yurut_anlik_o    = anlik_r;
  assign yurut_yasadisi_o = yasadisi_r;

endmodule
